// File: rtl/execute_muldiv_pkg.sv
// rtl/execute_muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package execute_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Constants are built at the widest supported width and sliced by the user.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] ovf_dividend(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    return (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/execute_muldiv_seq_if.sv
// rtl/execute_muldiv_seq_if.sv - ID/EX request and result bus of the muldiv sequencer
interface execute_muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_src_a;
  logic [DATA_WIDTH-1:0] i_src_b;
  logic                  i_flush;
  logic                  o_ready;
  logic                  o_stall;
  logic                  o_result_valid;
  logic [DATA_WIDTH-1:0] o_result;

  modport master (
    output i_valid, i_op, i_src_a, i_src_b, i_flush,
    input  o_ready, o_stall, o_result_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_src_a, i_src_b, i_flush,
    output o_ready, o_stall, o_result_valid, o_result
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// rtl/muldiv_iter_dp.sv - iterative shift-add multiply / restoring divide datapath with sign fix-up
module muldiv_iter_dp
  import execute_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  finish_i,
  input  muldiv_op_t            op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   operand_q, operand_d;
  muldiv_op_t     op_q, op_d;
  logic           neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic           sa, sb;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum, div_shift, div_trial;
  logic           q_bit;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] step_val, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign sa    = op_a_signed(op_i) & src_a_i[W-1];
  assign sb    = op_b_signed(op_i) & src_b_i[W-1];
  assign mag_a = sa ? -src_a_i : src_a_i;
  assign mag_b = sb ? -src_b_i : src_b_i;

  // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, operand_q} : '0);

  // Divide: acc = {partial remainder, dividend bits becoming quotient}, shifted left.
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_trial = div_shift - {1'b0, operand_q};
  assign q_bit     = ~div_trial[W];
  assign rem_next  = q_bit ? div_trial[W-1:0] : div_shift[W-1:0];

  assign step_val = op_is_div(op_q) ? {rem_next, acc_q[W-2:0], q_bit}
                                    : {mul_sum, acc_q[W-1:1]};

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -step_val : step_val;
  assign quot_fix = (neg_a_q ^ neg_b_q) ? -step_val[W-1:0] : step_val[W-1:0];
  assign rem_fix  = neg_a_q ? -step_val[2*W-1:W] : step_val[2*W-1:W];

  always_comb begin
    result_o = prod_fix[W-1:0];
    case (op_q)
      OP_MUL:                       result_o = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              result_o = quot_fix;
      OP_REM, OP_REMU:              result_o = rem_fix;
      default:                      result_o = prod_fix[W-1:0];
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    operand_d = operand_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    if (load_i) begin
      acc_d     = {{W{1'b0}}, (op_is_div(op_i) ? mag_a : mag_b)};
      operand_d = op_is_div(op_i) ? mag_b : mag_a;
      op_d      = op_i;
      neg_a_d   = sa;
      neg_b_d   = sb;
    end else if (finish_i) begin
      acc_d     = '0;
      operand_d = '0;
      neg_a_d   = 1'b0;
      neg_b_d   = 1'b0;
    end else if (step_i) begin
      acc_d = step_val;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      operand_q <= '0;
      op_q      <= OP_MUL;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
    end
  end
endmodule

// File: rtl/execute_muldiv_seq.sv
// rtl/execute_muldiv_seq.sv - execute-stage muldiv FSM, stall/handshake and result register
module execute_muldiv_seq
  import execute_muldiv_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  execute_muldiv_seq_if.slave  bus
);
  localparam logic [MAX_WIDTH-1:0]  OVF_FULL     = ovf_dividend(DATA_WIDTH);
  localparam logic [MAX_WIDTH-1:0]  ONES_FULL    = all_ones(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] OVF_DIVIDEND = OVF_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ALL_ONES     = ONES_FULL[DATA_WIDTH-1:0];

  muldiv_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] dp_result, fast_result;
  logic                  dp_load, dp_step, dp_finish;
  logic                  accept, div_zero, div_ovf, fast_path;
  muldiv_op_t            op_in;

  assign op_in     = muldiv_op_t'(bus.i_op);
  assign accept    = bus.i_valid && !bus.i_flush;
  assign div_zero  = op_is_div(op_in) && (bus.i_src_b == '0);
  assign div_ovf   = (op_in inside {OP_DIV, OP_REM}) && (bus.i_src_a == OVF_DIVIDEND)
                     && (bus.i_src_b == ALL_ONES);
  assign fast_path = div_zero || div_ovf;

  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = (op_in inside {OP_REM, OP_REMU}) ? bus.i_src_a : ALL_ONES;
    end else if (div_ovf) begin
      fast_result = (op_in == OP_REM) ? '0 : OVF_DIVIDEND;
    end
  end

  muldiv_iter_dp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dp (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .finish_i (dp_finish),
    .op_i     (op_in),
    .src_a_i  (bus.i_src_a),
    .src_b_i  (bus.i_src_b),
    .result_o (dp_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_finish = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fast_path) begin
            result_d = fast_result;
            state_d  = DONE;
          end else begin
            dp_load = 1'b1;
            cnt_d   = CNT_WIDTH'(DATA_WIDTH);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          dp_finish = 1'b1;
          result_d  = dp_result;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush discards the operation and leaves the last good result visible.
    if (bus.i_flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      result_d  = result_q;
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      dp_finish = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.o_ready        = (state_q == IDLE);
  assign bus.o_stall        = (state_q == BUSY) || ((state_q == IDLE) && accept);
  assign bus.o_result_valid = (state_q == DONE);
  assign bus.o_result       = result_q;
endmodule

// File: tb/tb_execute_muldiv_seq.sv
// tb/tb_execute_muldiv_seq.sv - randomized self-checking bench for execute_muldiv_seq
module tb_execute_muldiv_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  execute_muldiv_seq_if #(.DATA_WIDTH(32)) bus ();

  execute_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, sbz64;
    logic [63:0] ua64, ub64, p;
    int ia, ib;
    logic ovf;
    sa64  = {{32{a[31]}}, a};
    sb64  = {{32{b[31]}}, b};
    sbz64 = {32'd0, b};
    ua64  = {32'd0, a};
    ub64  = {32'd0, b};
    ia    = a;
    ib    = b;
    ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa64 * sb64;  return p[31:0];  end
      3'd1: begin p = sa64 * sb64;  return p[63:32]; end
      3'd2: begin p = sa64 * sbz64; return p[63:32]; end
      3'd3: begin p = ua64 * ub64;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold,
                       output logic [31:0] res, output int lat, output int stalls, output logic rdy);
    @(negedge clk);
    bus.i_op    = op;
    bus.i_src_a = a;
    bus.i_src_b = b;
    bus.i_valid = 1'b1;
    #1;
    rdy    = bus.o_ready;
    stalls = bus.o_stall ? 1 : 0;
    @(posedge clk);
    lat = 0;
    res = 'x;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.i_valid = 1'b0;
      #1;
      if (bus.o_result_valid) begin
        res = bus.o_result;
        break;
      end
      if (bus.o_stall) stalls++;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_op = 3'd0; bus.i_src_a = '0; bus.i_src_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", bus.o_stall); end
    checks++; if (bus.o_result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.o_result_valid); end
    checks++; if (bus.o_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [11] = '{3'd0, 3'd3, 3'd1, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'hFFFFFF9C,
                             32'hFFFFFF9C, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'd14, 32'd2, 32'hFFFFFFF2,
                             32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int          lexp[11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int lat, stalls;
    logic rdy;
    for (int i = 0; i < 11; i++) begin
      do_op(ops[i], as[i], bs[i], i[0], res, lat, stalls, rdy);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, exp[i]); end
      checks++; if (lat != lexp[i]) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, lexp[i]); end
      checks++; if (stalls != lexp[i]) begin failures++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected %0d", i, stalls, lexp[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, stalls, lexp;
    logic rdy;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(7, 0));
      a  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom();
      b  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom();
      exp  = ref_model(op, a, b);
      lexp = ref_latency(op, a, b);
      do_op(op, a, b, 1'($urandom_range(1, 0)), res, lat, stalls, rdy);
      checks++; if (res !== exp) begin failures++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp); end
      checks++; if (lat != lexp) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, lexp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, stalls, seen;
    logic rdy;
    do_op(3'd5, 32'd100, 32'd7, 1'b0, res, lat, stalls, rdy);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL flush_prior: got %h expected %h", res, 32'd14); end
    @(negedge clk);
    bus.i_op = 3'd5; bus.i_src_a = 32'd1000; bus.i_src_b = 32'd7; bus.i_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      if (c == 10) bus.i_flush = 1'b1;
      #1;
      if (bus.o_result_valid) seen++;
    end
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL flush_idle: got ready=%b expected 1", bus.o_ready); end
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", bus.o_stall); end
    checks++; if (bus.o_result_valid !== 1'b0 || seen != 0) begin failures++; $display("FAIL flush_no_pulse: got valid=%b pulses=%0d expected 0", bus.o_result_valid, seen); end
    checks++; if (bus.o_result !== 32'd14) begin failures++; $display("FAIL flush_result_hold: got %h expected %h", bus.o_result, 32'd14); end
    do_op(3'd5, 32'd9, 32'd3, 1'b0, res, lat, stalls, rdy);
    checks++; if (res !== 32'd3 || lat != 33) begin failures++; $display("FAIL flush_next_op: got %h lat %0d expected 3 lat 33", res, lat); end
  endtask

  task automatic test_flush_wins();
    @(negedge clk);
    bus.i_op = 3'd0; bus.i_src_a = 32'd3; bus.i_src_b = 32'd4; bus.i_valid = 1'b1; bus.i_flush = 1'b1;
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL flush_wins_stall: got %b expected 0", bus.o_stall); end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    #1;
    checks++; if (bus.o_ready !== 1'b1 || bus.o_result_valid !== 1'b0) begin failures++; $display("FAIL flush_wins_idle: got ready=%b valid=%b expected 1 0", bus.o_ready, bus.o_result_valid); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    bus.i_op = 3'd0; bus.i_src_a = 32'd11; bus.i_src_b = 32'd13; bus.i_valid = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", bus.o_ready); end
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %b expected 0", bus.o_stall); end
    checks++; if (bus.o_result !== 32'd0) begin failures++; $display("FAIL rst_mid_result: got %h expected 0", bus.o_result); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.o_result_valid) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rst_mid_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, res;
    int lat, stalls;
    logic rdy;
    a0 = $urandom(); b0 = $urandom();
    a1 = $urandom(); b1 = $urandom_range(1000, 1);
    do_op(3'd0, a0, b0, 1'b1, res, lat, stalls, rdy);
    checks++; if (res !== ref_model(3'd0, a0, b0)) begin failures++; $display("FAIL b2b_mul: got %h expected %h", res, ref_model(3'd0, a0, b0)); end
    do_op(3'd5, a1, b1, 1'b0, res, lat, stalls, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", rdy); end
    checks++; if (res !== a1 / b1 || lat != 33) begin failures++; $display("FAIL b2b_divu: got %h lat %0d expected %h lat 33", res, lat, a1 / b1); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_flush();
    test_flush_wins();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
